// File: rtl/sample_stream_player_if.sv
// FIFO read port and DAC sample port of the sample stream player.
// master = player side, slave = FIFO/DAC side.
interface sample_stream_player_if #(
  parameter int FIFO_W = 32,
  parameter int DAC_W  = 12
);
  logic [FIFO_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DAC_W-1:0]  ampl;
  logic              sample_stb;

  modport master (
    input  fifo_dout,
    input  fifo_empty,
    output fifo_rd_en,
    output ampl,
    output sample_stb
  );

  modport slave (
    output fifo_dout,
    output fifo_empty,
    input  fifo_rd_en,
    input  ampl,
    input  sample_stb
  );
endinterface

// File: rtl/sample_stream_player.sv
// Paced sample unpacker: pops packed FIFO words, emits one SAMPLE_W slice (LSB first) every rate_div clocks.
// Optional saturating underrun counter enabled by defining SSP_UNDERRUN_CNT_EN.
module sample_stream_player #(
  parameter int FIFO_W   = 32,
  parameter int SAMPLE_W = 8,
  parameter int DAC_W    = 12,
  parameter int DIV_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_W-1:0]     rate_div,
  input  logic                 scale_mode,
  sample_stream_player_if.master bus,
  output logic                 underrun,
  output logic                 busy,
  output logic [15:0]          underrun_cnt
);

  localparam int NSAMP = FIFO_W / SAMPLE_W;
  localparam int IDX_W = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int SHIFT = DAC_W - SAMPLE_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSAMP - 1);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(3);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              run_s;
  logic              rd_en_s;
  logic              leaving_s;
  logic              tick_s;
  logic [DIV_W-1:0]  div_eff_s;
  logic [DIV_W-1:0]  cnt_r;
  logic [FIFO_W-1:0] word_r;
  logic              word_valid_r;
  logic              pending_r;
  logic [IDX_W-1:0]  idx_r;
  logic [SAMPLE_W-1:0] sample_s;
  logic [DAC_W-1:0]  ampl_r;
  logic              sample_stb_r;
  logic              underrun_r;

  function automatic logic [DAC_W-1:0] format_sample(input logic [SAMPLE_W-1:0] s,
                                                     input logic left);
    logic [DAC_W-1:0] f;
    f = {DAC_W{1'b0}};
    f[SAMPLE_W-1:0] = s;
    if (left) begin
      f = f << SHIFT;
    end else begin
      f = f;
    end
    return f;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (enable) state_nxt_s = RUN;  else state_nxt_s = IDLE;
      RUN:     if (!enable) state_nxt_s = IDLE; else state_nxt_s = RUN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State decode: run flag and fetch strobe
  always_comb begin
    run_s   = 1'b0;
    rd_en_s = 1'b0;
    case (state_r)
      RUN: begin
        run_s   = 1'b1;
        rd_en_s = !word_valid_r && !pending_r && !bus.fifo_empty;
      end
      IDLE: begin
        run_s   = 1'b0;
        rd_en_s = 1'b0;
      end
      default: begin
        run_s   = 1'b0;
        rd_en_s = 1'b0;
      end
    endcase
  end

  assign leaving_s = run_s && (state_nxt_s == IDLE);
  assign div_eff_s = (rate_div < DIV_MIN) ? DIV_MIN : rate_div;
  assign tick_s    = run_s && (cnt_r >= (div_eff_s - DIV_W'(1)));
  assign sample_s  = word_r[int'(idx_r) * SAMPLE_W +: SAMPLE_W];

  // Tick counter, held at zero outside RUN so every start begins a fresh period
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt_r <= {DIV_W{1'b0}};
    else if (!run_s)  cnt_r <= {DIV_W{1'b0}};
    else if (tick_s)  cnt_r <= {DIV_W{1'b0}};
    else              cnt_r <= cnt_r + DIV_W'(1);
  end

  // Word buffer; a read still in flight when leaving RUN is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_r       <= {FIFO_W{1'b0}};
      word_valid_r <= 1'b0;
      pending_r    <= 1'b0;
      idx_r        <= {IDX_W{1'b0}};
    end else if (!run_s || leaving_s) begin
      word_valid_r <= 1'b0;
      pending_r    <= 1'b0;
      idx_r        <= {IDX_W{1'b0}};
    end else begin
      pending_r <= rd_en_s;
      if (pending_r) begin
        word_r       <= bus.fifo_dout;
        word_valid_r <= 1'b1;
        idx_r        <= {IDX_W{1'b0}};
      end else if (tick_s && word_valid_r) begin
        if (idx_r == IDX_LAST) begin
          word_valid_r <= 1'b0;
          idx_r        <= {IDX_W{1'b0}};
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end
    end
  end

  // Registered sample output and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ampl_r       <= {DAC_W{1'b0}};
      sample_stb_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      sample_stb_r <= tick_s && word_valid_r;
      underrun_r   <= tick_s && !word_valid_r;
      if (tick_s && word_valid_r) ampl_r <= format_sample(sample_s, scale_mode);
    end
  end

`ifdef SSP_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_r;

  // Saturating underrun counter, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_cnt_r <= 16'h0000;
    end else if (tick_s && !word_valid_r && (underrun_cnt_r != 16'hFFFF)) begin
      underrun_cnt_r <= underrun_cnt_r + 16'h0001;
    end
  end

  assign underrun_cnt = underrun_cnt_r;
`else
  assign underrun_cnt = 16'h0000;
`endif

  assign bus.fifo_rd_en = rd_en_s;
  assign bus.ampl       = ampl_r;
  assign bus.sample_stb = sample_stb_r;
  assign underrun       = underrun_r;
  assign busy           = (state_r == RUN);

endmodule

// File: doc/sample_stream_player.md
# sample_stream_player

Paced sample unpacker between the sample FIFO and `my_dac_top`. It replaces the fixed byte-to-12-bit mapping with a parametrised player. It pops packed words from a standard-mode FIFO, splits each word into SAMPLE_W samples (LSB first), and emits one sample every `rate_div` clocks on `ampl`. It reports underrun when the FIFO cannot keep up.

## Interface
Parameters:
- FIFO_W, 32, FIFO word width; must be a multiple of SAMPLE_W
- SAMPLE_W, 8, sample width; must be ≤ DAC_W
- DAC_W, 12, output amplitude width
- DIV_W, 32, width of rate divider

Ports:
- clk  in  1  system clock (okClk domain)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  1 = play; 0 = stop and flush
- rate_div  in  DIV_W  clocks per sample; values 0..2 are treated as 3
- scale_mode  in  1  0 = right-aligned (zero-extend); 1 = left-aligned (sample << (DAC_W-SAMPLE_W))
- fifo_dout  in  FIFO_W  FIFO read data, valid one cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read strobe
- ampl  out  DAC_W  amplitude to DAC controller
- sample_stb  out  1  one-cycle pulse when ampl updates
- underrun  out  1  one-cycle pulse when a tick finds no sample
- busy  out  1  1 while in RUN
- underrun_cnt  out  16  saturating underrun count (only with SSP_UNDERRUN_CNT_EN)

## Operation
- States: IDLE, RUN.
  - IDLE→RUN when enable=1.
  - RUN→IDLE on the cycle after enable=0.
- Entering RUN clears the tick counter `cnt` to 0.
- Entering IDLE clears word_valid and idx. The partial word is discarded.
- A read in flight at disable completes into the FIFO but its data is dropped.
- Fetch rule: in RUN, assert fifo_rd_en for exactly one cycle when all of these hold: !word_valid, !pending, !fifo_empty.
  - The read sets pending.
  - The next cycle loads word_r from fifo_dout, sets word_valid, clears idx and clears pending.
- Tick:
  - div_eff = max(rate_div, 3).
  - tick fires when cnt ≥ div_eff-1; cnt then returns to 0, otherwise cnt increments.
  - rate_div is sampled live.
- On a tick with word_valid:
  - ampl ← format(word_r[idx*SAMPLE_W +: SAMPLE_W]).
  - sample_stb=1.
  - idx increments. At idx = FIFO_W/SAMPLE_W-1, word_valid clears and idx returns to 0.
- On a tick without word_valid: ampl holds, underrun=1.
- format:
  - scale_mode=0 gives the sample zero-extended to DAC_W.
  - scale_mode=1 gives the sample shifted left by DAC_W-SAMPLE_W, LSBs zero.
  - scale_mode is sampled at the tick.
- A word emptied on a tick is refetched on the following cycle. With div_eff ≥ 3 the next word is valid before the next tick.
- busy = (state==RUN).

## Timing
- Reset values: ampl=0, sample_stb=0, underrun=0, fifo_rd_en=0, busy=0, underrun_cnt=0, state IDLE.
- Reset is asynchronous and effective mid-operation. No fifo_rd_en is asserted during reset.
- Start-up sequence from enable rising with the FIFO non-empty:
  - cycle 1: RUN.
  - cycle 2: fifo_rd_en.
  - cycle 3: word loaded.
  - First tick at div_eff cycles after RUN entry; ampl and sample_stb are registered one cycle after the tick condition.
- Sample period is exactly div_eff clocks in steady state.
- Tick and fetch in the same cycle are legal. The tick consumes the current word; the fetch is blocked until word_valid clears.

## Configuration
- SSP_UNDERRUN_CNT_EN defined:
  - underrun_cnt increments on every underrun pulse and saturates at 0xFFFF.
  - It clears only on reset.
- SSP_UNDERRUN_CNT_EN undefined:
  - the counter logic is absent and underrun_cnt is tied to 0.
  - The underrun pulse behaviour is unchanged.

## Test plan
Defaults for all scenarios: FIFO_W=32, SAMPLE_W=8, DAC_W=12.
- Basic play: FIFO holds 0x44332211, rate_div=4, scale_mode=0, enable=1 → ampl 0x011, 0x022, 0x033, 0x044, one sample_stb every 4 clocks; fifo_rd_en pulses exactly once.
- Scaling: same word, scale_mode=1 → ampl 0x110, 0x220, 0x330, 0x440.
- Underrun: single word, then FIFO empty → after 0x044, each subsequent tick pulses underrun, ampl holds 0x044; with the macro, underrun_cnt=3 after 3 ticks. Push 0x000000AA → next tick ampl=0x0AA, no underrun.
- Divider clamp: rate_div=0, then 1, then 2 → sample period 3 clocks in every case. Change rate_div to 10 mid-run → next period 10.
- Stop/flush: disable after 2 samples of 0x44332211, re-enable with FIFO holding 0x88776655 → next samples 0x055, 0x066; samples 0x033 and 0x044 are never output.
- Reset mid-play: assert reset between ticks → ampl=0, busy=0, fifo_rd_en=0 immediately; no sample_stb until re-enabled.
